// File: rtl/huffman_bit_aligner.sv
// Bit-level aligner for a Huffman decoder: keeps a left-aligned bit buffer, exposes
// the oldest MAX_CW bits to external width-w detectors and consumes the shortest match.
module huffman_bit_aligner #(
    parameter int IN_W   = 8,
    parameter int MAX_CW = 8,
    parameter int D_W    = 4,
    parameter int BUF_W  = 16,
    localparam int LEN_W = $clog2(MAX_CW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [MAX_CW-1:0]     win,
    input  logic [MAX_CW-1:0]     match_vec,
    input  logic [MAX_CW*D_W-1:0] match_data,
    output logic [D_W-1:0]        out_data,
    output logic [LEN_W-1:0]      out_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0] bits;
    logic [BUF_W-1:0] bits_shifted;
    logic [BUF_W-1:0] bits_next;
    logic [BUF_W-1:0] in_ext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_after;
    logic [CNT_W-1:0] cnt_next;
    logic             found;
    logic             fire;
    logic             take;
    logic             stuck;
    logic [LEN_W-1:0] sel_w;
    logic [D_W-1:0]   sel_data;

    assign win      = bits[BUF_W-1 -: MAX_CW];
    assign in_ready = (int'(cnt) <= BUF_W - IN_W) && !err;
    assign take     = in_valid && in_ready;

    // Scan from the widest code down so the shortest eligible width is the one kept.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found    = 1'b0;
        sel_w    = '0;
        sel_data = '0;
        for (int w = MAX_CW; w >= 1; w--) begin
            if (match_vec[w-1] && (w <= int'(cnt))) begin
                found    = 1'b1;
                sel_w    = LEN_W'(w);
                sel_data = match_data[(w-1)*D_W +: D_W];
            end
        end
    end

    assign fire  = found && !err && (!out_valid || out_ready);
    assign stuck = !found && (int'(cnt) >= MAX_CW);

    // New bits land right after the post-consume valid region.
    always_comb begin
        bits_shifted = fire ? (bits << sel_w) : bits;
        cnt_after    = fire ? (cnt - CNT_W'(sel_w)) : cnt;
        in_ext       = BUF_W'(in_data) << (BUF_W - IN_W);
        bits_next    = take ? (bits_shifted | (in_ext >> cnt_after)) : bits_shifted;
        cnt_next     = take ? (cnt_after + CNT_W'(IN_W)) : cnt_after;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // NOTE: the buffer itself is cleared, not just cnt, so bits below the valid region read as zero.
            bits      <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_len   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            bits <= bits_next;
            cnt  <= cnt_next;
            if (fire) begin
                out_data  <= sel_data;
                out_len   <= sel_w;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (stuck) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_bit_aligner.sv
// Directed bench for huffman_bit_aligner using the table {'0'->3, '10'->5, '110'->9}
// and an optional overlapping '000'->6 detector; a wide-buffer instance covers cnt=9 accept.
module tb_huffman_bit_aligner;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       w_flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       w_in_valid;
    logic       out_ready;
    bit         ovl;
    bit         use_wide;
    int         n_tests;
    int         n_fail;

    logic        in_ready, out_valid, err;
    logic [7:0]  win, match_vec;
    logic [31:0] match_data;
    logic [3:0]  out_data, out_len;

    logic        w_in_ready, w_out_valid, w_err;
    logic [7:0]  w_win, w_match_vec;
    logic [31:0] w_match_data;
    logic [3:0]  w_out_data, w_out_len;

    huffman_bit_aligner dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .win(win), .match_vec(match_vec), .match_data(match_data),
        .out_data(out_data), .out_len(out_len), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    huffman_bit_aligner #(.BUF_W(20)) u_wide (
        .clk(clk), .rst(rst), .flush(w_flush), .in_data(in_data), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .win(w_win), .match_vec(w_match_vec), .match_data(w_match_data),
        .out_data(w_out_data), .out_len(w_out_len), .out_valid(w_out_valid),
        .out_ready(out_ready), .err(w_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] det_vec(input logic [7:0] w, input bit o);
        logic [7:0] v;
        v = '0;
        v[0] = (w[7] == 1'b0);
        v[1] = (w[7:6] == 2'b10);
        v[2] = (w[7:5] == 3'b110) || (o && (w[7:5] == 3'b000));
        return v;
    endfunction

    function automatic logic [31:0] det_data(input logic [7:0] w, input bit o);
        logic [31:0] d;
        d = '0;
        if (w[7] == 1'b0)                 d[3:0]  = 4'd3;
        if (w[7:6] == 2'b10)              d[7:4]  = 4'd5;
        if (w[7:5] == 3'b110)             d[11:8] = 4'd9;
        if (o && (w[7:5] == 3'b000))      d[11:8] = 4'd6;
        return d;
    endfunction

    always_comb begin
        match_vec    = det_vec(win, ovl);
        match_data   = det_data(win, ovl);
        w_match_vec  = det_vec(w_win, ovl);
        w_match_data = det_data(w_win, ovl);
    end

    logic [8:0] o_sym;
    logic       o_ready;
    logic [7:0] o_win;
    int         o_cnt;
    assign o_sym   = use_wide ? {w_out_valid, w_out_len, w_out_data} : {out_valid, out_len, out_data};
    assign o_ready = use_wide ? w_in_ready : in_ready;
    assign o_win   = use_wide ? w_win : win;
    assign o_cnt   = use_wide ? int'(u_wide.cnt) : int'(dut.cnt);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sym(input string tag, input int d, input int l);
        tick;
        check(tag, 32'(o_sym), 32'({1'b1, 4'(l), 4'(d)}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; flush = 1'b0; w_flush = 1'b0; in_data = '0;
        in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b1; ovl = 1'b0; use_wide = 1'b0;
        tick; tick;
        check("rst_out",   32'(o_sym), 32'(0));
        check("rst_err",   32'(err), 32'(0));
        check("rst_win",   32'(win), 32'(0));
        check("rst_cnt",   32'(o_cnt), 32'(0));
        rst = 1'b0;
        #1 check("rst_ready", 32'(in_ready), 32'(1));

        // Single word decodes 3,5,9,3 back to back, leaving one '1' bit.
        in_data = 8'b0101_1001; in_valid = 1'b1; tick; in_valid = 1'b0;
        check("t1_accept_cnt", 32'(o_cnt), 32'(8));
        check("t1_no_early",   32'(out_valid), 32'(0));
        expect_sym("t1_s0", 3, 1);
        expect_sym("t1_s1", 5, 2);
        expect_sym("t1_s2", 9, 3);
        expect_sym("t1_s3", 3, 1);
        tick;
        check("t1_idle",  32'(out_valid), 32'(0));
        check("t1_cnt1",  32'(o_cnt), 32'(1));
        check("t1_win",   32'(win), 32'(8'h80));
        check("t1_noerr", 32'(err), 32'(0));

        // '110' split across words: stall on '11', 9 appears right after the next accept.
        flush = 1'b1; tick; flush = 1'b0;
        check("t2_flush_cnt", 32'(o_cnt), 32'(0));
        in_data = 8'b0100_0011; in_valid = 1'b1; tick; in_valid = 1'b0;
        expect_sym("t2_s0", 3, 1);
        expect_sym("t2_s1", 5, 2);
        expect_sym("t2_s2", 3, 1);
        expect_sym("t2_s3", 3, 1);
        expect_sym("t2_s4", 3, 1);
        tick;
        check("t2_stall_valid", 32'(out_valid), 32'(0));
        check("t2_stall_cnt",   32'(o_cnt), 32'(2));
        tick;
        check("t2_stall_err",   32'(err), 32'(0));
        in_data = 8'b0100_0000; in_valid = 1'b1; tick; in_valid = 1'b0;
        check("t2_accept_cnt",  32'(o_cnt), 32'(10));
        expect_sym("t2_s5", 9, 3);
        expect_sym("t2_s6", 5, 2);
        for (int i = 0; i < 5; i++) expect_sym("t2_tail", 3, 1);

        // Flush wins over a same-cycle accept and decode.
        in_data = 8'b0101_1001; in_valid = 1'b1; tick;
        flush = 1'b1; tick; flush = 1'b0; in_valid = 1'b0;
        check("t3_flush_cnt",   32'(o_cnt), 32'(0));
        check("t3_flush_valid", 32'(out_valid), 32'(0));
        check("t3_flush_win",   32'(win), 32'(0));

        // Backpressure: output held 5 cycles, buffer full, then lossless resume.
        in_data = 8'b0101_1010; in_valid = 1'b1; tick;
        in_data = 8'b1100_1000; tick;
        in_valid = 1'b0;
        check("t4_sym0",     32'(o_sym), 32'({1'b1, 4'd1, 4'd3}));
        check("t4_cnt15",    32'(o_cnt), 32'(15));
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t4_hold_sym",   32'(o_sym), 32'({1'b1, 4'd1, 4'd3}));
            check("t4_hold_cnt",   32'(o_cnt), 32'(15));
            check("t4_hold_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        expect_sym("t4_s1", 5, 2);
        expect_sym("t4_s2", 9, 3);
        expect_sym("t4_s3", 5, 2);
        expect_sym("t4_s4", 9, 3);
        expect_sym("t4_s5", 3, 1);
        expect_sym("t4_s6", 5, 2);
        expect_sym("t4_s7", 3, 1);
        expect_sym("t4_s8", 3, 1);
        tick;
        check("t4_idle_cnt", 32'(o_cnt), 32'(0));

        // Overlapping '0' and '000' detectors: the shorter width wins.
        ovl = 1'b1;
        in_data = 8'b0001_0110; in_valid = 1'b1; tick; in_valid = 1'b0;
        expect_sym("t5_s0_short", 3, 1);
        expect_sym("t5_s1", 3, 1);
        expect_sym("t5_s2", 3, 1);
        expect_sym("t5_s3", 5, 2);
        expect_sym("t5_s4", 9, 3);
        ovl = 1'b0;

        // Eight ones match nothing: sticky error, input blocked until flush.
        in_data = 8'hFF; in_valid = 1'b1; tick; in_valid = 1'b0;
        tick;
        check("t6_err",        32'(err), 32'(1));
        check("t6_ready",      32'(in_ready), 32'(0));
        check("t6_valid",      32'(out_valid), 32'(0));
        in_data = 8'h00; in_valid = 1'b1; tick;
        check("t6_blocked_cnt", 32'(o_cnt), 32'(8));
        check("t6_err_sticky",  32'(err), 32'(1));
        flush = 1'b1; tick; flush = 1'b0; in_valid = 1'b0;
        check("t6_flush_err",   32'(err), 32'(0));
        check("t6_flush_cnt",   32'(o_cnt), 32'(0));
        check("t6_flush_ready", 32'(in_ready), 32'(1));

        // Wide buffer: w=2 fire and accept in the same cycle starting from cnt=9.
        use_wide = 1'b1;
        in_data = 8'b0000_0001; w_in_valid = 1'b1; tick; w_in_valid = 1'b0;
        for (int i = 0; i < 7; i++) expect_sym("t7_pre", 3, 1);
        tick;
        check("t7_cnt1", 32'(o_cnt), 32'(1));
        in_data = 8'b0110_0000; w_in_valid = 1'b1; tick;
        check("t7_cnt9",  32'(o_cnt), 32'(9));
        check("t7_ready", 32'(o_ready), 32'(1));
        in_data = 8'b1001_1001; tick; w_in_valid = 1'b0;
        check("t7_cnt15", 32'(o_cnt), 32'(15));
        check("t7_fire",  32'(o_sym), 32'({1'b1, 4'd2, 4'd5}));
        expect_sym("t7_s1", 9, 3);
        for (int i = 0; i < 4; i++) expect_sym("t7_zeros", 3, 1);
        expect_sym("t7_s6", 5, 2);
        expect_sym("t7_s7", 3, 1);
        expect_sym("t7_s8", 9, 3);
        expect_sym("t7_s9", 3, 1);
        tick;
        check("t7_tail_cnt", 32'(o_cnt), 32'(1));
        check("t7_tail_win", 32'(o_win), 32'(8'h80));
        use_wide = 1'b0;

        // Reset with a pending unaccepted symbol discards everything.
        in_data = 8'b0101_1010; in_valid = 1'b1; tick; in_valid = 1'b0;
        out_ready = 1'b0; tick; tick;
        check("t8_pending", 32'(o_sym), 32'({1'b1, 4'd1, 4'd3}));
        rst = 1'b1; tick; rst = 1'b0;
        check("t8_rst_out",   32'(o_sym), 32'(0));
        check("t8_rst_err",   32'(err), 32'(0));
        check("t8_rst_win",   32'(win), 32'(0));
        check("t8_rst_cnt",   32'(o_cnt), 32'(0));
        check("t8_rst_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_bit_aligner.md
HUFFMAN_BIT_ALIGNER -- requirements
Module: huffman_bit_aligner

Interface
REQ-001 SHALL have parameter IN_W, default 8: input word width in bits.
REQ-002 SHALL have parameter MAX_CW, default 8: longest Huffman code width (1..MAX_CW supported).
REQ-003 SHALL have parameter D_W, default 4: decoded symbol width.
REQ-004 SHALL have parameter BUF_W, default 16: bit-buffer depth; legal only if BUF_W >= IN_W + MAX_CW - 1.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  synchronous stream restart: clears buffer, count, error and output register.
REQ-008 in_data  input  IN_W  compressed bitstream word; MSB is the earliest bit.
REQ-009 in_valid / in_ready  input / output  1 / 1  input handshake.
REQ-010 win  output  MAX_CW  oldest MAX_CW buffer bits; win[MAX_CW-1] is the oldest; width-w detector is wired to win[MAX_CW-1 -: w].
REQ-011 match_vec  input  MAX_CW  bit w-1 = width-w group detector reports code_matched.
REQ-012 match_data  input  MAX_CW*D_W  slice [(w-1)*D_W +: D_W] = width-w detector data_encoded.
REQ-013 out_data / out_len  output  D_W / clog2(MAX_CW+1)  decoded symbol and its code width.
REQ-014 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-015 err  output  1  sticky: no code matched although cnt >= MAX_CW.

Function
REQ-016 Buffer SHALL hold cnt valid bits (0..BUF_W), left-aligned; bits below the valid region SHALL read as 0.
REQ-017 in_ready SHALL be 1 iff cnt <= BUF_W - IN_W and err = 0, computed from registered cnt only.
REQ-018 Input transfer (in_valid && in_ready) SHALL append in_data immediately after the last valid bit (post-consume position when a consume occurs in the same cycle).
REQ-019 Candidate width w SHALL be eligible iff match_vec[w-1] = 1 and w <= cnt.
REQ-020 Selected width SHALL be the smallest eligible w; larger simultaneous matches SHALL be ignored.
REQ-021 Decode fires when an eligible w exists, err = 0, and (out_valid = 0 or out_ready = 1).
REQ-022 On fire: out_data <= match_data slice w, out_len <= w, out_valid <= 1, buffer shifts left by w, cnt decremented by w.
REQ-023 Same-cycle fire and input transfer: cnt_next = cnt - w + IN_W; no bit lost or duplicated.
REQ-024 out_valid SHALL clear when out_ready = 1 and no fire that cycle; output register SHALL hold while out_valid && !out_ready.
REQ-025 Latency: word accepted at edge N; first symbol out_valid at edge N+1 if its code lies in that word (window combinational from buffer).
REQ-026 Throughput: one symbol per cycle while eligible codes remain and output is accepted.
REQ-027 cnt < MAX_CW with no eligible w: stall (no error), wait for more input.
REQ-028 cnt >= MAX_CW with no eligible w: err <= 1; decode and input acceptance stop until flush or rst.
REQ-029 flush SHALL take priority over input and decode in the same cycle; flush and rst produce identical state.

Reset
REQ-030 On rst: cnt = 0, buffer = 0, win = 0, out_valid = 0, out_data = 0, out_len = 0, err = 0; in_ready = 1 the next cycle.
REQ-031 rst mid-stream SHALL discard buffered bits and any pending unaccepted output symbol.

Verification
REQ-032 Table {w1:'0'->3, w2:'10'->5, w3:'110'->9}; input 8'b0_10_110_0_1 (last bit padded), out_ready=1 -> symbols 3,5,9,3 with lengths 1,2,3,1 on consecutive cycles; cnt=1 remains.
REQ-033 Code straddling words: '110' split as word-end '11' + next word MSB '0' -> stall after '11', symbol 9 emitted the cycle after second word accepted.
REQ-034 out_ready held 0 for 5 cycles mid-stream -> out_data/out_len stable, buffer not consumed, in_ready drops once cnt > BUF_W-IN_W; resumes with no loss.
REQ-035 Eight 1 bits with table lacking any all-ones code of width <=8 -> err=1, in_ready=0, out_valid falls after accept; flush -> err=0, cnt=0.
REQ-036 Simultaneous fire (w=2) and input accept at cnt=9 -> cnt=15 next cycle, bit order checked against reference model.
REQ-037 rst asserted while out_valid=1, out_ready=0 -> next cycle all outputs at reset values.
